// File: rtl/div_iter_pkg.sv
// div_iter_pkg: shared muldiv widths and divider FSM state encodings
package div_iter_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step (combinational)
//   i_rem  partial remainder, always < i_dsr on entry
//   i_msb  dividend bit shifted in this step
//   i_dsr  divisor magnitude
//   o_rem  next partial remainder
//   o_qbit quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_msb,
  input  logic [WIDTH-1:0] i_dsr,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);
  // The shifted remainder needs WIDTH+1 bits since the divisor magnitude can
  // reach 2^(WIDTH-1) or more; one extra bit holds the borrow.
  logic [WIDTH+1:0] w_diff;
  assign w_diff = {1'b0, i_rem, i_msb} - {2'b00, i_dsr};
  assign o_qbit = ~w_diff[WIDTH+1];
  assign o_rem  = o_qbit ? w_diff[WIDTH-1:0] : {i_rem[WIDTH-2:0], i_msb};
endmodule

// File: rtl/div_iter.sv
// div_iter: sequential radix-2 restoring divider for MIPS DIV/DIVU
//   in_valid/in_ready   operand handshake (x dividend, y divisor, div_signed)
//   out_valid/out_ready result handshake (q -> LO, r -> HI)
//   cancel              pipeline flush, aborts any operation in progress
//   busy                high in CALC or DONE for hazard stalls
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cancel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy
);
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem, r_dvd, r_dsr, r_x, r_q, r_r;
  logic             r_sign_q, r_sign_r, r_div0;
  logic [WIDTH-1:0] w_ax, w_ay, w_rem_nxt, w_q_raw;
  logic             w_neg_x, w_neg_y, w_qbit, w_accept, w_last;
  assign w_neg_x  = div_signed & x[WIDTH-1];
  assign w_neg_y  = div_signed & y[WIDTH-1];
  assign w_ax     = w_neg_x ? -x : x;
  assign w_ay     = w_neg_y ? -y : y;
  assign w_accept = in_valid & (r_state == S_IDLE) & ~cancel;
  assign w_last   = r_cnt == CNT_W'(WIDTH - 1);
  // r_dvd doubles as the quotient register: dividend bits leave at the MSB
  // while quotient bits enter at the LSB.
  assign w_q_raw  = {r_dvd[WIDTH-2:0], w_qbit};
  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_msb  (r_dvd[WIDTH-1]),
    .i_dsr  (r_dsr),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dsr    <= '0;
      r_x      <= '0;
      r_q      <= '0;
      r_r      <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_div0   <= 1'b0;
    end else if (cancel && r_state != S_IDLE) begin
      r_state <= S_IDLE;
    end else if (w_accept) begin
      r_state  <= S_CALC;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dvd    <= w_ax;
      r_dsr    <= w_ay;
      r_x      <= x;
      r_sign_q <= w_neg_x ^ w_neg_y;
      r_sign_r <= w_neg_x;
      r_div0   <= y == '0;
    end else if (r_state == S_CALC) begin
      r_rem <= w_rem_nxt;
      r_dvd <= w_q_raw;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_state <= S_DONE;
        // Divide-by-zero still iterates for a fixed latency, then overrides.
        r_q <= r_div0 ? '1 : r_sign_q ? -w_q_raw : w_q_raw;
        r_r <= r_div0 ? r_x : r_sign_r ? -w_rem_nxt : w_rem_nxt;
      end
    end else if (r_state == S_DONE && out_ready) begin
      r_state <= S_IDLE;
    end
  end
  assign in_ready  = r_state == S_IDLE;
  assign busy      = r_state != S_IDLE;
  assign out_valid = r_state == S_DONE;
  assign q         = r_q;
  assign r         = r_r;
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed table-driven bench for div_iter
module tb_div_iter;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        div_signed = 1'b0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic        cancel = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] q;
  logic [31:0] r;
  logic        busy;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    logic        s;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;
  vec_t tv[9];
  always #5 clk = ~clk;
  div_iter dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .div_signed(div_signed), .x(x), .y(y), .cancel(cancel),
    .out_valid(out_valid), .out_ready(out_ready), .q(q), .r(r), .busy(busy)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    div_signed = s;
    x = a;
    y = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    div_signed = ~s;
    x = $urandom;
    y = $urandom;
  endtask
  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_lat"}, k, 32);
  endtask
  task automatic drain(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_ov_drop"}, {31'b0, out_valid}, 0);
    chk({name, "_in_ready"}, {31'b0, in_ready}, 1);
  endtask
  initial begin
    logic [31:0] hq, hr;
    tv[0] = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2};
    tv[1] = '{1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF};
    tv[2] = '{1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
    tv[3] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
    tv[4] = '{1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0};
    tv[5] = '{1'b0, 32'h00001234, 32'd0, 32'hFFFFFFFF, 32'h00001234};
    tv[6] = '{1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB};
    tv[7] = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000};
    tv[8] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE};
    #3;
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 9; i++) begin
      issue(tv[i].s, tv[i].x, tv[i].y);
      chk($sformatf("v%0d_busy", i), {31'b0, busy}, 1);
      wait_done($sformatf("v%0d", i));
      chk($sformatf("v%0d_q", i), q, tv[i].q);
      chk($sformatf("v%0d_r", i), r, tv[i].r);
      chk($sformatf("v%0d_done_in_ready", i), {31'b0, in_ready}, 0);
      drain($sformatf("v%0d", i));
    end
    // cancel at CALC cycle 10
    issue(1'b0, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_in_ready", {31'b0, in_ready}, 1);
    chk("cancel_busy", {31'b0, busy}, 0);
    begin
      logic seen;
      seen = 1'b0;
      repeat (40) begin
        @(negedge clk);
        seen = seen | out_valid;
      end
      chk("cancel_no_ov", {31'b0, seen}, 0);
    end
    // cancel in IDLE blocks acceptance
    @(negedge clk);
    in_valid = 1'b1;
    x = 32'd50;
    y = 32'd5;
    cancel = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cancel = 1'b0;
    chk("idle_cancel_busy", {31'b0, busy}, 0);
    // 9 / 3 then hold the result in DONE
    issue(1'b0, 32'd9, 32'd3);
    wait_done("nine");
    chk("nine_q", q, 3);
    chk("nine_r", r, 0);
    hq = q;
    hr = r;
    in_valid = 1'b1;
    x = 32'd77;
    y = 32'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_q", i), q, hq);
      chk($sformatf("hold%0d_r", i), r, hr);
      chk($sformatf("hold%0d_in_ready", i), {31'b0, in_ready}, 0);
      chk($sformatf("hold%0d_ov", i), {31'b0, out_valid}, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("hold_release_in_ready", {31'b0, in_ready}, 1);
    chk("hold_release_q", q, 3);
    // cancel wins over out_ready in DONE
    issue(1'b1, 32'hFFFFFF9C, 32'd10);
    wait_done("cdone");
    chk("cdone_q", q, 32'hFFFFFFF6);
    cancel = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    out_ready = 1'b0;
    chk("cdone_ov", {31'b0, out_valid}, 0);
    chk("cdone_in_ready", {31'b0, in_ready}, 1);
    // async reset mid-CALC
    issue(1'b0, 32'd55, 32'd4);
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("arst_ov", {31'b0, out_valid}, 0);
    chk("arst_busy", {31'b0, busy}, 0);
    chk("arst_q", q, 0);
    chk("arst_r", r, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("arst_in_ready", {31'b0, in_ready}, 1);
    issue(1'b0, 32'd55, 32'd4);
    wait_done("post_rst");
    chk("post_rst_q", q, 13);
    chk("post_rst_r", r, 3);
    drain("post_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Sequential radix-2 restoring divider for the MIPS DIV/DIVU path. It is the inverse-operation companion of the Booth/Wallace multiplier in the EX-stage muldiv unit.
- Accepts one dividend/divisor pair through a valid/ready handshake and iterates one quotient bit per cycle.
- Returns quotient and remainder (LO/HI) through a second valid/ready handshake.
- Supports pipeline flush via cancel.

Parameters:
WIDTH, 32, operand/quotient/remainder width; must be >= 4.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  divider idle, can accept operands
div_signed  input  1  1 = DIV (signed), 0 = DIVU
x  input  WIDTH  dividend
y  input  WIDTH  divisor
cancel  input  1  flush; abort any operation in progress
out_valid  output  1  result valid
out_ready  input  1  consumer takes result
q  output  WIDTH  quotient (to LO)
r  output  WIDTH  remainder (to HI)
busy  output  1  high in CALC or DONE, used for hazard stall

Behaviour:
- Reset (resetn low, async): state = IDLE, in_ready = 1, out_valid = 0, busy = 0, q = 0, r = 0, counter = 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1.
  - A transfer occurs when in_valid && in_ready && !cancel.
  - On transfer, latch |x|, |y|, sign_q = signed & (x[MSB] ^ y[MSB]), sign_r = signed & x[MSB], div0 = (y == 0).
  - Absolute value applies only when div_signed = 1.
  - Next state: CALC, counter = 0.
- CALC, one step per cycle:
  - Form trial = {rem[WIDTH-2:0], dvd[MSB]} - divisor, WIDTH+1 bits.
  - If non-negative, rem = trial and the quotient bit is 1. Otherwise rem is kept with the shifted-in bit and the quotient bit is 0.
  - Shift the quotient bit into the dividend register LSB.
  - After WIDTH steps (counter == WIDTH-1), go to DONE.
  - Sign fix-up happens on the DONE entry edge: q = sign_q ? -Q : Q, r = sign_r ? -R : R.
- Latency: the operand transfer is at edge N. out_valid is high after edge N+WIDTH, i.e. 32 CALC cycles for WIDTH = 32.
- DONE:
  - out_valid = 1. q and r are stable and held.
  - On out_ready go to IDLE; out_valid drops the next cycle.
  - No new operand is accepted in DONE (in_ready = 0), even in the cycle out_ready is high.
- Divide by zero (div0): the iteration runs normally for a fixed latency. Result is forced to q = all-ones and r = x (original dividend), for both signed and unsigned.
- Signed overflow: x = 0x80000000, y = 0xFFFFFFFF (signed) gives q = 0x80000000, r = 0. This falls out of 2^31 magnitude arithmetic and needs no special case.
- Cancel:
  - In CALC or DONE, cancel forces IDLE on the next edge. out_valid = 0 and the result is discarded.
  - In IDLE, cancel blocks acceptance in that cycle.
  - cancel has priority over out_ready and in_valid.
- Remainder sign follows the dividend and quotient truncates toward zero, per MIPS.
- in_ready = (state == IDLE); busy = (state != IDLE). Both are purely state-decoded with no input-to-output combinational path, except that the acceptance qualifier uses cancel.
- Operands x, y and div_signed are sampled only on the transfer cycle. Later changes are ignored.

Decomposition:
- Shared package/header: state encodings (IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2) and WIDTH defaults shared with the multiplier path.
- One natural sub-module: div_step. It is combinational, takes the partial remainder, dividend MSB and divisor, and outputs the next remainder and quotient bit. It is unit-testable standalone.
- Control FSM, counter and sign fix-up stay in div_iter.

Test Plan:
- Unsigned basic: DIVU x = 100, y = 7 → after 32 cycles, out_valid = 1, q = 14, r = 2; out_ready = 1 → in_ready = 1 next cycle.
- Signed mixes: DIV x = -7 (0xFFFFFFF9), y = 2 → q = -3 (0xFFFFFFFD), r = -1 (0xFFFFFFFF). DIV x = 7, y = -2 → q = -3, r = 1.
- Boundary: DIV 0x80000000 / 0xFFFFFFFF → q = 0x80000000, r = 0. DIVU 0xFFFFFFFF / 1 → q = 0xFFFFFFFF, r = 0.
- Divide by zero: DIVU x = 0x1234, y = 0 → q = 0xFFFFFFFF, r = 0x1234 at the same 32-cycle latency.
- Cancel/handshake:
  - Assert cancel at CALC cycle 10 → IDLE next edge, out_valid never rises.
  - Then issue 9 / 3 → q = 3, r = 0.
  - Hold out_ready = 0 for 5 cycles in DONE → q and r stable, in_ready = 0 throughout.
- Async reset: assert resetn = 0 mid-CALC (between clock edges) → out_valid, busy, q and r go to 0 immediately. in_ready = 1 after release.
